dvp_pattern_tx: RTL and testbench

//  DVP (OV5640-compatible) video source: emits vsync/href/8-bit RGB565 byte stream, high byte first,
//  one byte per clk. Transmit end of the camera capture path. Drives the ov5640_dri capture inputs in

---
 rtl/dvp_tx_pkg.sv | 8 +
 rtl/dvp_pattern_gen.sv | 16 +
 rtl/dvp_pattern_tx.sv | 100 ++++++++++
 tb/tb_dvp_pattern_tx.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/dvp_tx_pkg.sv
// dvp_tx_pkg: shared FSM states, pattern codes and colour-bar palette for the DVP pattern source.
package dvp_tx_pkg;
  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_e;
  typedef enum logic [1:0] {PAT_BARS, PAT_RAMP, PAT_COORD, PAT_SOLID} pattern_e;
  localparam logic [7:0][15:0] BAR_RGB = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F, 16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };
endpackage

// File: rtl/dvp_pattern_gen.sv
// dvp_pattern_gen: combinational RGB565 pixel for one active-region coordinate.
module dvp_pattern_gen
  import dvp_tx_pkg::*;
(
  input  logic [15:0] x,
  input  logic [7:0]  y,
  input  logic [2:0]  bar,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid,
  output logic [15:0] pixel
);
  always_comb
    pixel = pattern == PAT_BARS  ? BAR_RGB[bar] :
            pattern == PAT_RAMP  ? x :
            pattern == PAT_COORD ? {y, x[7:0]} : solid;
endmodule

// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: DVP video source emitting vsync/href and RGB565 bytes (high byte first).
// Next-cycle position is computed combinationally so every output can be registered in step with it.
module dvp_pattern_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_PIXEL  = 1280,
  parameter int V_PIXEL  = 1920,
  parameter int H_TOTAL  = 1290,
  parameter int V_TOTAL  = 1940,
  parameter int VS_LINES = 4,
  parameter int V_BP     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_rgb,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);
  localparam int HW    = $clog2(2 * H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);
  localparam int BW    = $clog2(H_PIXEL / 8) + 1;
  localparam int V_ACT = VS_LINES + V_BP;
  localparam int V_FP  = V_ACT + V_PIXEL;
  state_e state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d, y_d;
  logic [BW-1:0] bx_q, bx_d;
  logic [2:0] bi_q, bi_d;
  logic [1:0] pat_q;
  logic [15:0] solid_q, pixel;
  logic h_end, href_d, done_d;
  dvp_pattern_gen u_gen (
    .x      (16'(h_d >> 1)),
    .y      (8'(y_d)),
    .bar    (bi_d),
    .pattern(pat_q),
    .solid  (solid_q),
    .pixel  (pixel)
  );
  always_comb begin
    h_end   = h_q == HW'(2 * H_TOTAL - 1);
    state_d = IDLE;
    h_d     = '0;
    v_d     = '0;
    bx_d    = '0;
    bi_d    = '0;
    if (state_q == IDLE || (h_end && v_q == VW'(V_TOTAL - 1))) state_d = enable ? VSYNC : IDLE;
    else begin
      h_d = h_end ? '0 : h_q + HW'(1);
      v_d = h_end ? v_q + VW'(1) : v_q;
      state_d = v_d < VW'(VS_LINES) ? VSYNC : v_d < VW'(V_ACT) ? VBP : v_d < VW'(V_FP) ? ACTIVE : VFP;
      // bar index advances on each new pixel once the current bar is full
      if (h_d != '0) begin
        bx_d = h_d[0] ? bx_q : bx_q == BW'(H_PIXEL / 8 - 1) ? '0 : bx_q + BW'(1);
        bi_d = (h_d[0] || bx_q != BW'(H_PIXEL / 8 - 1)) ? bi_q : bi_q + 3'd1;
      end
    end
    y_d    = v_d - VW'(V_ACT);
    href_d = state_d == ACTIVE && h_d < HW'(2 * H_PIXEL);
    done_d = state_d != IDLE && h_d == HW'(2 * H_TOTAL - 1) && v_d == VW'(V_TOTAL - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      h_q        <= '0;
      v_q        <= '0;
      bx_q       <= '0;
      bi_q       <= '0;
      pat_q      <= '0;
      solid_q    <= '0;
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      bx_q    <= bx_d;
      bi_q    <= bi_d;
      if (state_d == VSYNC && state_q != VSYNC) begin
        pat_q   <= pattern;
        solid_q <= solid_rgb;
      end
      cam_vsync  <= state_d == VSYNC;
      cam_href   <= href_d;
      cam_data   <= href_d ? (h_d[0] ? pixel[7:0] : pixel[15:8]) : '0;
      busy       <= state_d != IDLE;
      frame_done <= done_d;
      frame_cnt  <= frame_cnt + 16'(done_d);
    end
endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb_dvp_pattern_tx: directed + randomized frames checked against a per-clock frame-timing model.
module tb_dvp_pattern_tx;
  localparam int HP = 16, VP = 4, HT = 20, VT = 12, VS = 2, VB = 2;
  localparam int LINE = 2 * HT, FRAME = LINE * VT;
  logic clk = 0, rst_n = 0, enable = 0;
  logic [1:0] pattern = 0;
  logic [15:0] solid_rgb = 0;
  logic cam_vsync, cam_href, busy, frame_done;
  logic [7:0] cam_data;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0;
  logic [15:0] exp_frames = 0;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [1:0] cp, np;
  logic [15:0] cs, ns;

  dvp_pattern_tx #(.H_PIXEL(HP), .V_PIXEL(VP), .H_TOTAL(HT), .V_TOTAL(VT), .VS_LINES(VS), .V_BP(VB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern(pattern), .solid_rgb(solid_rgb),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] obs();
    return {cam_vsync, cam_href, cam_data, busy, frame_done, frame_cnt};
  endfunction

  function automatic logic [15:0] px(input logic [1:0] p, input logic [15:0] s, input int x, input int y);
    case (p)
      2'd0:    return bars[x / (HP / 8)];
      2'd1:    return 16'(x);
      2'd2:    return {8'(y), 8'(x)};
      default: return s;
    endcase
  endfunction

  // expected outputs at clock t of a frame, from line/column arithmetic
  function automatic logic [27:0] model(input logic [1:0] p, input logic [15:0] s, input int t);
    int line = t / LINE, hc = t % LINE;
    logic vs = line < VS;
    logic hr = line >= VS + VB && line < VS + VB + VP && hc < 2 * HP;
    logic dn = t == FRAME - 1;
    logic [15:0] pix = hr ? px(p, s, hc / 2, line - VS - VB) : 16'h0;
    logic [7:0] d = hr ? (hc % 2 == 1 ? pix[7:0] : pix[15:8]) : 8'h00;
    return {vs, hr, d, 1'b1, dn, 16'(exp_frames + 16'(dn))};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e, input int t);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, o, e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle", 32'(obs()), 32'({12'h000, exp_frames}), i);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_frame(input logic [1:0] p, input logic [15:0] s, input logic [1:0] nxp,
                           input logic [15:0] nxs, input bit scramble, input int drop_at);
    int hrefs = 0, bytes = 0, vs_clks = 0;
    logic prev = 0;
    logic [7:0] c_hi = 0, c_lo = 0;
    for (int t = 0; t < FRAME; t++) begin
      chk("frame", 32'(obs()), 32'(model(p, s, t)), t);
      hrefs += int'(cam_href && !prev);
      prev = cam_href;
      bytes += int'(cam_href);
      vs_clks += int'(cam_vsync);
      if (t == (VS + VB + 2) * LINE + 10) c_hi = cam_data;
      if (t == (VS + VB + 2) * LINE + 11) c_lo = cam_data;
      if (t == drop_at) enable = 0;
      if (scramble && t < FRAME - LINE) begin
        pattern = 2'($urandom);
        solid_rgb = 16'($urandom);
      end else begin
        pattern = nxp;
        solid_rgb = nxs;
      end
      @(posedge clk); #1;
    end
    exp_frames++;
    chk("href_pulses", 32'(hrefs), VP, 0);
    chk("href_bytes", 32'(bytes), VP * 2 * HP, 0);
    chk("vsync_clks", 32'(vs_clks), VS * LINE, 0);
    if (p == 2'd2) chk("coord_y2_x5", {16'h0, c_hi, c_lo}, 32'h0205, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 32'(obs()), 32'h0, 0);
    rst_n = 1;
    idle(100);
    pattern = 3;
    solid_rgb = 16'hABCD;
    enable = 1;
    @(posedge clk); #1;
    run_frame(2'd3, 16'hABCD, 2'd0, 16'h1234, 0, -1);
    chk("cnt_after_first", 32'(frame_cnt), 32'd1, 0);
    run_frame(2'd0, 16'h1234, 2'd2, 16'h5555, 0, -1);
    cp = 2'($urandom);
    cs = 16'($urandom);
    run_frame(2'd2, 16'h5555, cp, cs, 0, -1);
    for (int f = 0; f < 4; f++) begin
      np = 2'($urandom);
      ns = 16'($urandom);
      run_frame(cp, cs, np, ns, 1, f == 3 ? (VS + VB + 1) * LINE + 5 : -1);
      cp = np;
      cs = ns;
    end
    idle(20);
    pattern = 1;
    enable = 1;
    @(posedge clk); #1;
    for (int t = 0; t < (VS + VB + 1) * LINE + 7; t++) begin
      chk("pre_reset", 32'(obs()), 32'(model(2'd1, cs, t)), t);
      @(posedge clk); #1;
    end
    rst_n = 0;
    enable = 0;
    #1;
    chk("async_reset", 32'(obs()), 32'h0, 0);
    exp_frames = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 32'(obs()), 32'h0, 0);
    rst_n = 1;
    idle(10);
    pattern = 0;
    enable = 1;
    @(posedge clk); #1;
    run_frame(2'd0, cs, 2'd3, 16'hFFFF, 0, (VS + VB + 2) * LINE + 3);
    idle(20);
    chk("cnt_after_drop", 32'(frame_cnt), 32'd1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
